uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 9: maximum data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: baud_clock cycles per bit, even, at least 4.
REQ-003 Parameter FIFO_DEPTH, default 8: transmit FIFO entries, power of 2, at least 2.
REQ-004 Port baud_clock, input, 1: single clock; every flop is rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port wr_data, input, DATA_W: word to queue.
REQ-007 Port wr_valid, input, 1: wr_data is valid.
REQ-008 Port wr_ready, output, 1: FIFO can accept a word; equals !full.
REQ-009 Port data_length, input, 4: data bits per frame, 5..9; any other value means DATA_W.
REQ-010 Port num_stop_bit, input, 2: 01 or 00 = 1 stop bit, 10 = 1.5, 11 = 2.
REQ-011 Port parity_mode, input, 2: 00 none, 01 odd, 10 even, 11 mark.
REQ-012 Port tx_enable, input, 1: MCR1-style transmitter enable.
REQ-013 Port n_CTS, input, 1: clear-to-send, active-low.
REQ-014 Port serial_data_out, output, 1: line output; idles high.
REQ-015 Port n_RTS, output, 1: active-low request-to-send.
REQ-016 Port tx_busy, output, 1: a frame is in progress.
REQ-017 Port tx_done, output, 1: one-cycle pulse on the last stop-bit cycle.
REQ-018 Port fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-019 A write occurs when wr_valid && wr_ready; a write while full is ignored and must not corrupt the FIFO.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when FIFO is non-empty, tx_enable=1 and n_CTS=0.
- On that transition, pop one word and latch data_length, num_stop_bit and parity_mode for the whole frame.
REQ-021 Start-bit timing: serial_data_out goes low the cycle after the pop.
- Start bit and each data/parity bit last exactly OVERSAMPLE cycles.
- Stop lasts OVERSAMPLE, 3*OVERSAMPLE/2 or 2*OVERSAMPLE cycles, driven high.
REQ-022 Data is sent LSB first; only the latched length of bits is sent; higher bits are dropped.
REQ-023 Parity bit = XOR of the sent data bits, inverted for odd; mark sends 1; none skips PARITY.
REQ-024 STOP -> START directly (no idle cycle) when the next-frame start conditions hold on the last stop cycle; otherwise STOP -> IDLE.
REQ-025 n_CTS or tx_enable deasserting mid-frame does not abort the frame; only new frame starts are gated.
REQ-026 Simultaneous write and pop: count is unchanged; a write to an empty FIFO may be popped the following cycle at earliest.
REQ-027 n_RTS = !(tx_enable && (fifo non-empty || tx_busy)), registered.
REQ-028 Counters: bit counter 4 bits, cycle counter $clog2(2*OVERSAMPLE) bits; both clear on each state change; no wrap reachable.

Reset
REQ-029 Reset values: serial_data_out=1, n_RTS=1, tx_busy=0, tx_done=0, wr_ready=1, fifo_count=0, FSM=IDLE, FIFO pointers 0.
REQ-030 Reset asserted mid-frame takes effect next edge; the line returns high and queued data is discarded.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined, parity follows REQ-023.
REQ-032 Without UART_TX_PARITY_EN:
- PARITY state and parity logic are absent.
- parity_mode is ignored and behaves as 00.

Structure
REQ-033 Package uart_pkg holds the FSM state enum, the parity_mode/num_stop_bit encodings and a default OVERSAMPLE constant.
REQ-034 Sub-module uart_tx_fifo: synchronous FIFO with write/pop/full/empty/count, parametrised width and depth.

Verification
REQ-035 Reset, write 0x55, 8 bits, 1 stop, no parity -> line low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, high 16 cycles, tx_done pulse.
REQ-036 Write 0x0F, 7 bits, even parity, 2 stop -> parity bit 0, stop high 32 cycles; with odd parity -> parity bit 1.
REQ-037 Write 9 words with depth 8 and the line held by n_CTS=1 -> wr_ready=0 after 8 words; 9th dropped; fifo_count=8.
REQ-038 Two queued words, 1.5 stop -> second start bit follows 24 high cycles with no idle gap.
REQ-039 n_CTS raised mid-data -> frame completes, no next start until n_CTS=0; reset mid-frame -> line high next cycle, fifo_count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter:
// FSM state encoding, line-format encodings and the default oversample ratio.
package uart_pkg;

    // Baud-clock cycles per bit when the instantiating block does not override it
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Transmit FSM states; PARITY is only reachable when parity support is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // parity_mode port encoding
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_t;

    // num_stop_bit port encoding (00 and 01 both mean a single stop bit)
    typedef enum logic [1:0] {
        STOP_1   = 2'b00,
        STOP_1B  = 2'b01,
        STOP_1P5 = 2'b10,
        STOP_2   = 2'b11
    } stop_mode_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Writes are ignored while full and pops are ignored while empty, so the
// pointers can never be corrupted by an over- or under-run.
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_write;
    logic             do_pop;

    assign do_write = wr_en && !full;
    assign do_pop   = rd_en && !empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a transmit FIFO and CTS/RTS flow control.
// Optional feature macro: UART_TX_PARITY_EN -- when defined, a parity bit is
// sent according to parity_mode; when undefined, parity_mode is ignored and
// frames never carry a parity bit.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          baud_clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [3:0]                    data_length,
    input  logic [1:0]                    num_stop_bit,
    input  logic [1:0]                    parity_mode,
    input  logic                          tx_enable,
    input  logic                          n_CTS,
    output logic                          serial_data_out,
    output logic                          n_RTS,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(2*OVERSAMPLE);
    localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);

    tx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [3:0]        bit_cnt;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start_ok;
    logic              pop;
    logic              next_bit;

    // Frame descriptor captured at the pop and held for the whole frame
    logic [DATA_W-1:0] data_q;
    logic [3:0]        len_q;
    logic [CW-1:0]     stop_last_q;
`ifdef UART_TX_PARITY_EN
    logic              par_en_q;
    logic              par_bit_q;
`else
    logic              unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // Out-of-range or longer-than-supported lengths fall back to DATA_W
    function automatic logic [3:0] eff_length(input logic [3:0] dl);
        if (dl >= 4'd5 && dl <= 4'(DATA_W)) return dl;
        else                                 return 4'(DATA_W);
    endfunction

    // Index of the final stop-bit cycle for the requested stop length
    function automatic logic [CW-1:0] stop_last(input logic [1:0] ns);
        case (stop_mode_t'(ns))
            STOP_1P5: return CW'(3*OVERSAMPLE/2 - 1);
            STOP_2:   return CW'(2*OVERSAMPLE - 1);
            default:  return CW'(OVERSAMPLE - 1);
        endcase
    endfunction

    // Select one bit of the frame word by a bit-counter value
    function automatic logic bit_at(input logic [DATA_W-1:0] d, input logic [3:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) == idx) b = d[i];
        end
        return b;
    endfunction

`ifdef UART_TX_PARITY_EN
    // Parity over only the bits that will actually be sent
    function automatic logic parity_of(input logic [DATA_W-1:0] d,
                                       input logic [3:0]        len,
                                       input logic [1:0]        mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < len) acc = acc ^ d[i];
        end
        case (parity_mode_t'(mode))
            PAR_ODD:  return ~acc;
            PAR_EVEN: return acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (baud_clock),
        .reset   (reset),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign wr_ready = !fifo_full;
    assign start_ok = !fifo_empty && tx_enable && !n_CTS;
    // A frame starts from IDLE, or straight out of the last stop cycle
    assign pop      = start_ok &&
                      ((state == IDLE) || ((state == STOP) && (cnt == stop_last_q)));
    assign next_bit = bit_at(data_q, bit_cnt + 4'd1);

    // Latch the popped word and the line format for the frame being started
    always_ff @(posedge baud_clock) begin
        if (pop) begin
            data_q      <= fifo_rd_data;
            len_q       <= eff_length(data_length);
            stop_last_q <= stop_last(num_stop_bit);
`ifdef UART_TX_PARITY_EN
            par_en_q    <= (parity_mode != PAR_NONE);
            par_bit_q   <= parity_of(fifo_rd_data, eff_length(data_length), parity_mode);
`endif
        end
    end

    // Transmit FSM with registered line, busy and done outputs
    always_ff @(posedge baud_clock) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            serial_data_out <= 1'b1;
            tx_busy         <= 1'b0;
            tx_done         <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state           <= START;
                        cnt             <= '0;
                        bit_cnt         <= '0;
                        serial_data_out <= 1'b0;
                        tx_busy         <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == OS_LAST) begin
                        state           <= DATA;
                        cnt             <= '0;
                        bit_cnt         <= '0;
                        serial_data_out <= data_q[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == OS_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == len_q - 4'd1) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state           <= PARITY;
                                serial_data_out <= par_bit_q;
                            end else begin
                                state           <= STOP;
                                serial_data_out <= 1'b1;
                            end
`else
                            state           <= STOP;
                            serial_data_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt         <= bit_cnt + 4'd1;
                            serial_data_out <= next_bit;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == OS_LAST) begin
                        state           <= STOP;
                        cnt             <= '0;
                        bit_cnt         <= '0;
                        serial_data_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == stop_last_q) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        if (pop) begin
                            state           <= START;
                            serial_data_out <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        // Registered pulse lands on the final stop cycle
                        if (cnt == stop_last_q - CW'(1)) tx_done <= 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    cnt             <= '0;
                    bit_cnt         <= '0;
                    serial_data_out <= 1'b1;
                    tx_busy         <= 1'b0;
                end
            endcase
        end
    end

    // Request-to-send: asserted (low) while enabled and there is work queued or in flight
    always_ff @(posedge baud_clock) begin
        if (reset) n_RTS <= 1'b1;
        else       n_RTS <= !(tx_enable && (!fifo_empty || tx_busy));
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param (default parameters). Expected line waveforms
// are built cycle by cycle from the frame format rules; honours the
// UART_TX_PARITY_EN build option in its reference model.
module tb_uart_tx_param;

    localparam int DW    = 9;
    localparam int OS    = 16;
    localparam int DEPTH = 8;

    logic          baud_clock = 1'b0;
    logic          reset;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    data_length;
    logic [1:0]    num_stop_bit;
    logic [1:0]    parity_mode;
    logic          tx_enable;
    logic          n_CTS;
    logic          serial_data_out;
    logic          n_RTS;
    logic          tx_busy;
    logic          tx_done;
    logic [3:0]    fifo_count;

    int total = 0;
    int bad   = 0;

    logic exp_q[$];
    logic line_buf[$];
    logic done_buf[$];
    logic rts_buf[$];

    always #5 baud_clock = ~baud_clock;

    uart_tx_param #(.DATA_W(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .baud_clock      (baud_clock),
        .reset           (reset),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .data_length     (data_length),
        .num_stop_bit    (num_stop_bit),
        .parity_mode     (parity_mode),
        .tx_enable       (tx_enable),
        .n_CTS           (n_CTS),
        .serial_data_out (serial_data_out),
        .n_RTS           (n_RTS),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .fifo_count      (fifo_count)
    );

    // ---------------- reference model ----------------
    function automatic int model_len(input logic [3:0] dl);
        return (dl >= 5 && dl <= DW) ? int'(dl) : DW;
    endfunction

    function automatic int model_stop(input logic [1:0] ns);
        if (ns == 2'b10) return (3*OS)/2;
        if (ns == 2'b11) return 2*OS;
        return OS;
    endfunction

    // Expected serial line, one entry per baud_clock cycle, from start bit to last stop cycle
    function automatic void build_wave(input logic [DW-1:0] d, input logic [3:0] dl,
                                       input logic [1:0] ns, input logic [1:0] pm);
        int   n;
        int   ones;
        logic pbit;
        logic [1:0] p;
        n = model_len(dl);
        p = pm;
`ifndef UART_TX_PARITY_EN
        p = 2'b00;
`endif
        exp_q.delete();
        for (int c = 0; c < OS; c++) exp_q.push_back(1'b0);
        ones = 0;
        for (int b = 0; b < n; b++) begin
            ones += int'(d[b]);
            for (int c = 0; c < OS; c++) exp_q.push_back(d[b]);
        end
        if (p != 2'b00) begin
            if (p == 2'b11)      pbit = 1'b1;
            else if (p == 2'b10) pbit = (ones % 2 == 1);
            else                 pbit = (ones % 2 == 0);
            for (int c = 0; c < OS; c++) exp_q.push_back(pbit);
        end
        for (int c = 0; c < model_stop(ns); c++) exp_q.push_back(1'b1);
    endfunction

    function automatic int wave_errs(output int first);
        int e;
        e = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= line_buf.size() || line_buf[i] !== exp_q[i]) begin
                e++;
                if (first < 0) first = i;
            end
        end
        return e;
    endfunction

    // Position of the single tx_done pulse; -1 none, -2 more than one
    function automatic int done_pos();
        int p;
        p = -1;
        for (int i = 0; i < done_buf.size(); i++) begin
            if (done_buf[i] === 1'b1) p = (p == -1) ? i : -2;
        end
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input logic [3:0] dl, input logic [1:0] ns, input logic [1:0] pm);
        data_length  = dl;
        num_stop_bit = ns;
        parity_mode  = pm;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge baud_clock);
        wr_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (serial_data_out === 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge baud_clock);
        end
    endtask

    // Record n cycles starting with the current one; optionally raise n_CTS at cycle cts_at
    task automatic capture(input int n, input int cts_at);
        line_buf.delete();
        done_buf.delete();
        rts_buf.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge baud_clock);
            if (i == cts_at) n_CTS = 1'b1;
            line_buf.push_back(serial_data_out);
            done_buf.push_back(tx_done);
            rts_buf.push_back(n_RTS);
        end
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge baud_clock);
            if (serial_data_out !== 1'b1) lows++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_enable = 1'b0; n_CTS = 1'b1;
        set_cfg(4'd8, 2'b00, 2'b00);
        repeat (3) @(negedge baud_clock);
        total++; if (serial_data_out !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", serial_data_out); end
        total++; if (n_RTS !== 1'b1) begin bad++; $display("FAIL reset_rts got=%b want=1", n_RTS); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tx_done); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", wr_ready); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        reset = 1'b0;
        @(negedge baud_clock);
    endtask

    task automatic test_basic_55();
        int e, f, dp;
        set_cfg(4'd8, 2'b00, 2'b00);
        tx_enable = 1'b1; n_CTS = 1'b0;
        push_word(9'h055);
        total++; if (serial_data_out !== 1'b1 || fifo_count !== 4'd1) begin
            bad++; $display("FAIL basic_pre_pop line=%b count=%0d want line=1 count=1", serial_data_out, fifo_count); end
        @(negedge baud_clock);
        total++; if (serial_data_out !== 1'b0 || fifo_count !== 4'd0 || tx_busy !== 1'b1) begin
            bad++; $display("FAIL basic_start line=%b count=%0d busy=%b want 0/0/1", serial_data_out, fifo_count, tx_busy); end
        build_wave(9'h055, 4'd8, 2'b00, 2'b00);
        capture(exp_q.size(), -1);
        e = wave_errs(f);
        total++; if (e !== 0) begin bad++; $display("FAIL basic_wave errs=%0d at=%0d got=%b want=%b", e, f, line_buf[f], exp_q[f]); end
        dp = done_pos();
        total++; if (dp !== exp_q.size() - 1) begin bad++; $display("FAIL basic_done pos=%0d want=%0d", dp, exp_q.size() - 1); end
        total++; if (rts_buf[OS] !== 1'b0) begin bad++; $display("FAIL basic_rts got=%b want=0", rts_buf[OS]); end
        @(negedge baud_clock);
        total++; if (tx_busy !== 1'b0 || serial_data_out !== 1'b1) begin
            bad++; $display("FAIL basic_idle busy=%b line=%b want 0/1", tx_busy, serial_data_out); end
    endtask

    task automatic test_parity();
        int e, f;
        bit ok;
        logic [1:0] modes [2];
        logic want_p;
        modes[0] = 2'b10;
        modes[1] = 2'b01;
        for (int m = 0; m < 2; m++) begin
            set_cfg(4'd7, 2'b11, modes[m]);
            push_word(9'h00F);
            wait_start(20, ok);
            total++; if (!ok) begin bad++; $display("FAIL parity_start got=timeout want=start"); return; end
            build_wave(9'h00F, 4'd7, 2'b11, modes[m]);
            capture(exp_q.size(), -1);
            e = wave_errs(f);
            total++; if (e !== 0) begin bad++; $display("FAIL parity_wave mode=%0d errs=%0d at=%0d got=%b want=%b", modes[m], e, f, line_buf[f], exp_q[f]); end
`ifdef UART_TX_PARITY_EN
            want_p = (modes[m] == 2'b01);
`else
            want_p = 1'b1;
`endif
            total++; if (line_buf[8*OS + OS/2] !== want_p) begin
                bad++; $display("FAIL parity_bit mode=%0d got=%b want=%b", modes[m], line_buf[8*OS + OS/2], want_p); end
            @(negedge baud_clock);
        end
    endtask

    task automatic test_full_back_to_back();
        logic [DW-1:0] w [9];
        logic [3:0] dl;
        logic [1:0] pm;
        int e, f, lows, dp;
        bit ok;
        n_CTS = 1'b1; tx_enable = 1'b1;
        dl = 4'($urandom_range(5, 9));
        pm = 2'($urandom_range(0, 3));
        set_cfg(dl, 2'b10, pm);
        for (int i = 0; i < 9; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 9; i++) begin
            wr_data = w[i]; wr_valid = 1'b1;
            total++; if (wr_ready !== (i < 8)) begin bad++; $display("FAIL full_ready word=%0d got=%b want=%b", i, wr_ready, (i < 8)); end
            @(negedge baud_clock);
        end
        wr_valid = 1'b0;
        total++; if (fifo_count !== 4'd8 || wr_ready !== 1'b0) begin
            bad++; $display("FAIL full_count count=%0d ready=%b want 8/0", fifo_count, wr_ready); end
        count_lows(20, lows);
        total++; if (lows !== 0 || n_RTS !== 1'b0) begin bad++; $display("FAIL full_held lows=%0d rts=%b want 0/0", lows, n_RTS); end
        n_CTS = 1'b0;
        wait_start(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_start got=timeout want=start"); return; end
        for (int k = 0; k < 8; k++) begin
            build_wave(w[k], dl, 2'b10, pm);
            capture(exp_q.size(), -1);
            e = wave_errs(f);
            total++; if (e !== 0) begin bad++; $display("FAIL b2b_wave frame=%0d errs=%0d at=%0d got=%b want=%b", k, e, f, line_buf[f], exp_q[f]); end
            dp = done_pos();
            total++; if (dp !== exp_q.size() - 1) begin bad++; $display("FAIL b2b_done frame=%0d pos=%0d want=%0d", k, dp, exp_q.size() - 1); end
            @(negedge baud_clock);
        end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL b2b_empty count=%0d want=0", fifo_count); end
        count_lows(2*OS, lows);
        total++; if (lows !== 0) begin bad++; $display("FAIL b2b_ninth lows=%0d want=0", lows); end
    endtask

    task automatic test_cts_midframe();
        logic [DW-1:0] a, b;
        int e, f, lows;
        bit ok;
        a = DW'($urandom); b = DW'($urandom);
        set_cfg(4'd8, 2'b00, 2'b00);
        n_CTS = 1'b0; tx_enable = 1'b1;
        push_word(a);
        push_word(b);
        wait_start(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL cts_start got=timeout want=start"); return; end
        build_wave(a, 4'd8, 2'b00, 2'b00);
        capture(exp_q.size(), 3*OS);
        e = wave_errs(f);
        total++; if (e !== 0) begin bad++; $display("FAIL cts_wave errs=%0d at=%0d got=%b want=%b", e, f, line_buf[f], exp_q[f]); end
        count_lows(3*OS, lows);
        total++; if (lows !== 0 || fifo_count !== 4'd1 || tx_busy !== 1'b0) begin
            bad++; $display("FAIL cts_hold lows=%0d count=%0d busy=%b want 0/1/0", lows, fifo_count, tx_busy); end
        n_CTS = 1'b0;
        wait_start(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL cts_resume got=timeout want=start"); return; end
        build_wave(b, 4'd8, 2'b00, 2'b00);
        capture(exp_q.size(), -1);
        e = wave_errs(f);
        total++; if (e !== 0) begin bad++; $display("FAIL cts_wave2 errs=%0d at=%0d got=%b want=%b", e, f, line_buf[f], exp_q[f]); end
        @(negedge baud_clock);
    endtask

    task automatic test_enable_gate();
        logic [DW-1:0] d;
        int e, f, lows;
        bit ok;
        d = DW'($urandom);
        set_cfg(4'd9, 2'b01, 2'b11);
        tx_enable = 1'b0; n_CTS = 1'b0;
        push_word(d);
        count_lows(2*OS, lows);
        total++; if (lows !== 0 || n_RTS !== 1'b1) begin bad++; $display("FAIL enable_gate lows=%0d rts=%b want 0/1", lows, n_RTS); end
        tx_enable = 1'b1;
        wait_start(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL enable_start got=timeout want=start"); return; end
        build_wave(d, 4'd9, 2'b01, 2'b11);
        capture(exp_q.size(), -1);
        e = wave_errs(f);
        total++; if (e !== 0) begin bad++; $display("FAIL enable_wave errs=%0d at=%0d got=%b want=%b", e, f, line_buf[f], exp_q[f]); end
        @(negedge baud_clock);
    endtask

    task automatic test_reset_midframe();
        int lows;
        bit ok;
        set_cfg(4'd8, 2'b00, 2'b00);
        n_CTS = 1'b0; tx_enable = 1'b1;
        push_word(9'h000);
        push_word(9'h1A5);
        wait_start(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_start got=timeout want=start"); return; end
        repeat (30) @(negedge baud_clock);
        reset = 1'b1;
        @(negedge baud_clock);
        total++; if (serial_data_out !== 1'b1 || fifo_count !== 4'd0 || tx_busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_now line=%b count=%0d busy=%b want 1/0/0", serial_data_out, fifo_count, tx_busy); end
        reset = 1'b0;
        count_lows(3*OS, lows);
        total++; if (lows !== 0 || fifo_count !== 4'd0) begin bad++; $display("FAIL rstmid_after lows=%0d count=%0d want 0/0", lows, fifo_count); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic [3:0] dl;
        logic [1:0] ns, pm;
        int e, f, dp;
        bit ok;
        n_CTS = 1'b0; tx_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d  = DW'($urandom);
            dl = 4'($urandom_range(0, 15));
            ns = 2'($urandom_range(0, 3));
            pm = 2'($urandom_range(0, 3));
            set_cfg(dl, ns, pm);
            push_word(d);
            wait_start(20, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_start iter=%0d got=timeout want=start", k); return; end
            build_wave(d, dl, ns, pm);
            capture(exp_q.size(), -1);
            e = wave_errs(f);
            total++; if (e !== 0) begin
                bad++; $display("FAIL rand_wave iter=%0d d=%h dl=%0d ns=%0d pm=%0d errs=%0d at=%0d got=%b want=%b", k, d, dl, ns, pm, e, f, line_buf[f], exp_q[f]); end
            dp = done_pos();
            total++; if (dp !== exp_q.size() - 1) begin bad++; $display("FAIL rand_done iter=%0d pos=%0d want=%0d", k, dp, exp_q.size() - 1); end
            @(negedge baud_clock);
        end
    endtask

    initial begin
        @(negedge baud_clock);
        test_reset();
        test_basic_55();
        test_parity();
        test_full_back_to_back();
        test_cts_midframe();
        test_enable_gate();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends on its own
    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
